// File: rtl/branch_resolve_unit.sv
// Same-cycle branch resolution from forwarded operands, plus a 2-bit
// counter PHT that supplies registered predictions to fetch.
module branch_resolve_unit #(
   parameter int DATA_W    = 32,
   parameter int PHT_DEPTH = 64,
   parameter int IDX_LSB   = 2,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              lookup_valid,
   input  logic [31:0]       lookup_pc,
   output logic              pred_valid,
   output logic              pred_taken,
   input  logic              res_valid,
   input  logic [31:0]       res_pc,
   input  logic [5:0]        res_op,
   input  logic [4:0]        res_rt,
   input  logic [DATA_W-1:0] res_a,
   input  logic [DATA_W-1:0] res_b,
   input  logic              res_pred_taken,
   output logic              res_is_branch,
   output logic              res_taken,
   output logic              res_link,
   output logic              res_mispredict,
   output logic [CNT_W-1:0]  branch_cnt,
   output logic [CNT_W-1:0]  mispred_cnt
);

   localparam int IDX_W = $clog2(PHT_DEPTH);

   logic [1:0]       r_pht [PHT_DEPTH];
   logic             r_pred_valid;
   logic             r_pred_taken;
   logic [CNT_W-1:0] r_branch_cnt;
   logic [CNT_W-1:0] r_mispred_cnt;

   logic             w_is_br;
   logic             w_taken;
   logic             w_link;
   logic             w_mispred;
   logic             w_sign;
   logic             w_zero;
   logic [IDX_W-1:0] w_res_idx;
   logic [IDX_W-1:0] w_lk_idx;
   logic [1:0]       w_cur;
   logic [1:0]       w_nxt;
   logic [1:0]       w_lk_ent;
   logic             w_unused;

   assign w_sign = res_a[DATA_W-1];
   assign w_zero = (res_a == '0);

   always_comb begin
      w_is_br = 1'b0;
      w_taken = 1'b0;
      w_link  = 1'b0;
      if (res_valid) begin
         case (res_op)
            6'b000100: begin
               w_is_br = 1'b1;
               w_taken = (res_a == res_b);
            end
            6'b000101: begin
               w_is_br = 1'b1;
               w_taken = (res_a != res_b);
            end
            6'b000110: begin
               w_is_br = 1'b1;
               w_taken = w_sign | w_zero;
            end
            6'b000111: begin
               w_is_br = 1'b1;
               w_taken = ~w_sign & ~w_zero;
            end
            6'b000001: begin
               case (res_rt)
                  5'b00000, 5'b10000: begin
                     w_is_br = 1'b1;
                     w_taken = w_sign;
                     w_link  = res_rt[4];
                  end
                  5'b00001, 5'b10001: begin
                     w_is_br = 1'b1;
                     w_taken = ~w_sign;
                     w_link  = res_rt[4];
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   assign w_mispred = w_is_br & (w_taken ^ res_pred_taken);

   assign res_is_branch  = w_is_br;
   assign res_taken      = w_taken;
   assign res_link       = w_link;
   assign res_mispredict = w_mispred;

   assign w_res_idx = res_pc[IDX_LSB +: IDX_W];
   assign w_lk_idx  = lookup_pc[IDX_LSB +: IDX_W];
   assign w_cur     = r_pht[w_res_idx];

   always_comb begin
      w_nxt = w_cur;
      if (w_taken) begin
         if (w_cur != 2'b11) w_nxt = w_cur + 2'b01;
      end else begin
         if (w_cur != 2'b00) w_nxt = w_cur - 2'b01;
      end
   end

   // Write-first: a lookup hitting the entry being updated sees the new value
   assign w_lk_ent = (w_is_br && (w_lk_idx == w_res_idx)) ?
                     w_nxt : r_pht[w_lk_idx];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < PHT_DEPTH; i++) r_pht[i] <= 2'b01;
      end else if (w_is_br) begin
         r_pht[w_res_idx] <= w_nxt;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pred_valid <= 1'b0;
         r_pred_taken <= 1'b0;
      end else begin
         r_pred_valid <= lookup_valid;
         if (lookup_valid) r_pred_taken <= w_lk_ent[1];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_branch_cnt  <= '0;
         r_mispred_cnt <= '0;
      end else begin
         if (w_is_br && !(&r_branch_cnt))
            r_branch_cnt <= r_branch_cnt + 1'b1;
         if (w_mispred && !(&r_mispred_cnt))
            r_mispred_cnt <= r_mispred_cnt + 1'b1;
      end
   end

   assign pred_valid  = r_pred_valid;
   assign pred_taken  = r_pred_taken;
   assign branch_cnt  = r_branch_cnt;
   assign mispred_cnt = r_mispred_cnt;

   assign w_unused = ^{lookup_pc, res_pc};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Table-driven and randomized checks of branch_resolve_unit against
// an array-based PHT and counter model.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        resetn;
   logic        lookup_valid;
   logic [31:0] lookup_pc;
   logic        res_valid;
   logic [31:0] res_pc;
   logic [5:0]  res_op;
   logic [4:0]  res_rt;
   logic [31:0] res_a;
   logic [31:0] res_b;
   logic        res_pred_taken;

   logic        pred_valid, pred_taken;
   logic        res_is_branch, res_taken, res_link, res_mispredict;
   logic [15:0] branch_cnt, mispred_cnt;
   logic        pv4, pt4, isb4, tk4, lk4, mp4;
   logic [3:0]  bc4, mc4;

   int checks = 0;
   int errors = 0;

   int m_pht [64];
   int m_bc, m_mc;
   bit m_pv, m_pt;
   bit e_isb, e_tk, e_lk, e_mp;

   always #5 clk = ~clk;

   branch_resolve_unit u_dut (
      .clk(clk), .resetn(resetn),
      .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
      .pred_valid(pred_valid), .pred_taken(pred_taken),
      .res_valid(res_valid), .res_pc(res_pc),
      .res_op(res_op), .res_rt(res_rt),
      .res_a(res_a), .res_b(res_b),
      .res_pred_taken(res_pred_taken),
      .res_is_branch(res_is_branch), .res_taken(res_taken),
      .res_link(res_link), .res_mispredict(res_mispredict),
      .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   branch_resolve_unit #(.CNT_W(4)) u_dut4 (
      .clk(clk), .resetn(resetn),
      .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
      .pred_valid(pv4), .pred_taken(pt4),
      .res_valid(res_valid), .res_pc(res_pc),
      .res_op(res_op), .res_rt(res_rt),
      .res_a(res_a), .res_b(res_b),
      .res_pred_taken(res_pred_taken),
      .res_is_branch(isb4), .res_taken(tk4),
      .res_link(lk4), .res_mispredict(mp4),
      .branch_cnt(bc4), .mispred_cnt(mc4)
   );

   typedef struct {
      logic [5:0]  op;
      logic [4:0]  rt;
      logic [31:0] a;
      logic [31:0] b;
      bit          pred;
      bit          isb;
      bit          tk;
      bit          lk;
      bit          mp;
   } vec_t;

   vec_t vecs [15];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void ref_res(input logic [5:0] op,
                                   input logic [4:0] rt,
                                   input logic [31:0] a,
                                   input logic [31:0] b,
                                   output bit isb, output bit tk,
                                   output bit lk);
      int sa;
      sa  = $signed(a);
      isb = 1'b0;
      tk  = 1'b0;
      lk  = 1'b0;
      if (op == 6'd4) begin
         isb = 1; tk = (a == b);
      end else if (op == 6'd5) begin
         isb = 1; tk = (a != b);
      end else if (op == 6'd6) begin
         isb = 1; tk = (sa <= 0);
      end else if (op == 6'd7) begin
         isb = 1; tk = (sa > 0);
      end else if (op == 6'd1 && (rt == 5'd0 || rt == 5'd16)) begin
         isb = 1; tk = (sa < 0); lk = (rt == 5'd16);
      end else if (op == 6'd1 && (rt == 5'd1 || rt == 5'd17)) begin
         isb = 1; tk = (sa >= 0); lk = (rt == 5'd17);
      end
   endfunction

   function automatic int sat15(input int v);
      return (v > 15) ? 15 : v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) m_pht[i] = 1;
      m_bc = 0; m_mc = 0; m_pv = 0; m_pt = 0;
   endtask

   task automatic drive(input bit lv, input logic [31:0] lpc,
                        input bit rv, input logic [31:0] rpc,
                        input logic [5:0] op, input logic [4:0] rt,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit pp);
      lookup_valid = lv; lookup_pc = lpc;
      res_valid = rv; res_pc = rpc; res_op = op; res_rt = rt;
      res_a = a; res_b = b; res_pred_taken = pp;
   endtask

   task automatic check_regs(input string tag);
      chk({tag, "_pv"}, pred_valid, m_pv);
      chk({tag, "_pt"}, pred_taken, m_pt);
      chk({tag, "_bc"}, branch_cnt, m_bc);
      chk({tag, "_mc"}, mispred_cnt, m_mc);
      chk({tag, "_bc4"}, bc4, sat15(m_bc));
      chk({tag, "_mc4"}, mc4, sat15(m_mc));
   endtask

   // Called just after a falling edge with inputs already driven
   task automatic cycle(input string tag);
      int ri, li;
      ref_res(res_op, res_rt, res_a, res_b, e_isb, e_tk, e_lk);
      e_isb = e_isb & res_valid;
      e_tk  = e_tk & e_isb;
      e_lk  = e_lk & e_isb;
      e_mp  = e_isb & (e_tk != res_pred_taken);
      #1;
      chk({tag, "_isb"}, res_is_branch, e_isb);
      chk({tag, "_tk"}, res_taken, e_tk);
      chk({tag, "_lk"}, res_link, e_lk);
      chk({tag, "_mp"}, res_mispredict, e_mp);
      chk({tag, "_tk4"}, tk4, e_tk);
      @(posedge clk);
      ri = (res_pc / 4) % 64;
      li = (lookup_pc / 4) % 64;
      if (e_isb) begin
         if (e_tk) m_pht[ri] = (m_pht[ri] == 3) ? 3 : m_pht[ri] + 1;
         else      m_pht[ri] = (m_pht[ri] == 0) ? 0 : m_pht[ri] - 1;
         m_bc++;
         if (e_mp) m_mc++;
      end
      m_pv = lookup_valid;
      if (lookup_valid) m_pt = (m_pht[li] >= 2);
      #1;
      check_regs(tag);
      @(negedge clk);
   endtask

   initial begin
      vecs[0]  = '{6'd7, 5'd0,  32'h8000_0000, 32'd0, 0, 1, 0, 0, 0};
      vecs[1]  = '{6'd6, 5'd0,  32'h8000_0000, 32'd0, 1, 1, 1, 0, 0};
      vecs[2]  = '{6'd1, 5'd16, 32'h8000_0000, 32'd0, 0, 1, 1, 1, 1};
      vecs[3]  = '{6'd1, 5'd17, 32'h8000_0000, 32'd0, 0, 1, 0, 1, 0};
      vecs[4]  = '{6'd1, 5'd3,  32'h8000_0000, 32'd0, 1, 0, 0, 0, 0};
      vecs[5]  = '{6'd4, 5'd0,  32'd5, 32'd5, 1, 1, 1, 0, 0};
      vecs[6]  = '{6'd5, 5'd0,  32'd5, 32'd5, 1, 1, 0, 0, 1};
      vecs[7]  = '{6'd5, 5'd0,  32'd5, 32'd6, 0, 1, 1, 0, 1};
      vecs[8]  = '{6'd1, 5'd0,  32'd0, 32'd0, 0, 1, 0, 0, 0};
      vecs[9]  = '{6'd1, 5'd1,  32'd0, 32'd0, 0, 1, 1, 0, 1};
      vecs[10] = '{6'd7, 5'd0,  32'd1, 32'd0, 1, 1, 1, 0, 0};
      vecs[11] = '{6'd6, 5'd0,  32'd0, 32'd0, 0, 1, 1, 0, 1};
      vecs[12] = '{6'd6, 5'd0,  32'h7fff_ffff, 32'd0, 0, 1, 0, 0, 0};
      vecs[13] = '{6'd2, 5'd0,  32'd5, 32'd5, 1, 0, 0, 0, 0};
      vecs[14] = '{6'd4, 5'd0,  32'd5, 32'd6, 0, 1, 0, 0, 0};

      resetn = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      #12;
      check_regs("rst");
      @(negedge clk);
      resetn = 1'b1;

      drive(1, 32'h0040_0000, 0, 0, 0, 0, 0, 0, 0);
      cycle("lk0");
      chk("lk0_const_pv", pred_valid, 1);
      chk("lk0_const_pt", pred_taken, 0);

      drive(0, 0, 1, 32'h100, 6'd4, 0, 32'd5, 32'd5, 0);
      cycle("beq1");
      chk("beq1_bc_const", branch_cnt, 1);
      chk("beq1_mc_const", mispred_cnt, 1);
      drive(0, 0, 1, 32'h100, 6'd4, 0, 32'd5, 32'd5, 0);
      cycle("beq2");
      drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
      cycle("lk1");
      chk("lk1_const_pt", pred_taken, 1);

      drive(0, 0, 0, 32'h300, 6'd4, 0, 32'd5, 32'd5, 0);
      #1;
      chk("novalid_isb", res_is_branch, 0);
      chk("novalid_tk", res_taken, 0);
      chk("novalid_mp", res_mispredict, 0);
      cycle("novalid");

      foreach (vecs[i]) begin
         drive(0, 0, 1, 32'h300, vecs[i].op, vecs[i].rt,
               vecs[i].a, vecs[i].b, vecs[i].pred);
         #1;
         chk($sformatf("vec%0d_isb", i), res_is_branch, vecs[i].isb);
         chk($sformatf("vec%0d_tk", i), res_taken, vecs[i].tk);
         chk($sformatf("vec%0d_lk", i), res_link, vecs[i].lk);
         chk($sformatf("vec%0d_mp", i), res_mispredict, vecs[i].mp);
         cycle($sformatf("vec%0d", i));
      end

      // entry at 0x400 starts 01; one taken brings it to 10
      drive(0, 0, 1, 32'h400, 6'd4, 0, 32'd1, 32'd1, 0);
      cycle("wf_train");
      drive(1, 32'h400, 1, 32'h400, 6'd4, 0, 32'd1, 32'd2, 1);
      cycle("wf");
      chk("wf_const_pt", pred_taken, 0);
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 1, 32'h400, 6'd5, 0, 32'd1, 32'd1, 0);
         cycle("sat0");
      end
      drive(0, 0, 1, 32'h400, 6'd4, 0, 32'd1, 32'd1, 0);
      cycle("sat0_up");
      drive(1, 32'h400, 0, 0, 0, 0, 0, 0, 0);
      cycle("sat0_lk");
      chk("sat0_const_pt", pred_taken, 0);

      for (int k = 0; k < 20; k++) begin
         drive(0, 0, 1, 32'h500, 6'd4, 0, 32'd9, 32'd9, 0);
         cycle("cnt");
      end
      chk("cnt4_bc_const", bc4, 4'd15);
      chk("cnt4_mc_const", mc4, 4'd15);

      for (int k = 0; k < 400; k++) begin
         logic [5:0]  op;
         logic [4:0]  rt;
         logic [31:0] a, b, rpc, lpc;
         case ($urandom_range(0, 9))
            0, 1: op = 6'd4;
            2: op = 6'd5;
            3: op = 6'd6;
            4: op = 6'd7;
            5, 6, 7: op = 6'd1;
            default: op = 6'($urandom);
         endcase
         case ($urandom_range(0, 5))
            0: rt = 5'd0;
            1: rt = 5'd1;
            2: rt = 5'd16;
            3: rt = 5'd17;
            default: rt = 5'($urandom);
         endcase
         case ($urandom_range(0, 5))
            0: a = 32'd0;
            1: a = 32'h8000_0000;
            2: a = 32'h7fff_ffff;
            3: a = 32'hffff_ffff;
            4: a = 32'($urandom_range(0, 3));
            default: a = $urandom;
         endcase
         b = ($urandom_range(0, 2) == 0) ? a : 32'($urandom_range(0, 3));
         rpc = 32'h1000 + 4 * $urandom_range(0, 7);
         lpc = ($urandom_range(0, 1) == 1) ? rpc :
               32'h1000 + 4 * $urandom_range(0, 7);
         if ($urandom_range(0, 7) == 0) lpc = $urandom;
         drive($urandom_range(0, 1), lpc, $urandom_range(0, 4) != 0,
               rpc, op, rt, a, b, $urandom_range(0, 1));
         cycle("rnd");
      end

      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 1, 32'h204, 6'd4, 0, 32'd3, 32'd3, 1);
         cycle("tr");
      end
      drive(1, 32'h204, 0, 0, 0, 0, 0, 0, 0);
      cycle("tr_lk");
      chk("tr_const_pt", pred_taken, 1);

      // asynchronous reset mid-cycle, no clock edge in between
      drive(1, 32'h204, 1, 32'h204, 6'd4, 0, 32'd3, 32'd3, 0);
      #2;
      resetn = 1'b0;
      model_reset();
      #1;
      check_regs("arst");
      @(posedge clk);
      #1;
      check_regs("arst_hold");
      @(negedge clk);
      resetn = 1'b1;
      drive(1, 32'h204, 0, 0, 0, 0, 0, 0, 0);
      cycle("arst_lk");
      chk("arst_const_pt", pred_taken, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution and prediction block for the MIPS pipeline. It sits alongside decode. It resolves conditional branches from forwarded operands in the same cycle, and keeps a pattern history table (PHT) of 2-bit saturating counters that supplies registered predictions to fetch. It also flags mispredictions for flush and maintains saturating branch and misprediction statistics counters.

## Interface
Parameters:
- DATA_W, 32, operand width; compares are two's-complement signed.
- PHT_DEPTH, 64, number of PHT entries; power of two, at least 2; IDX_W = log2(PHT_DEPTH).
- IDX_LSB, 2, lowest PC bit used for the PHT index.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- lookup_valid  in  1  fetch requests a prediction this cycle.
- lookup_pc  in  32  PC being predicted.
- pred_valid  out  1  registered; high the cycle after an accepted lookup.
- pred_taken  out  1  registered; prediction for the last lookup.
- res_valid  in  1  a decoded instruction is presented for resolution.
- res_pc  in  32  PC of the instruction being resolved.
- res_op  in  6  instruction opcode field.
- res_rt  in  5  instruction rt field, used for REGIMM.
- res_a  in  DATA_W  rs operand, already forwarded.
- res_b  in  DATA_W  rt operand, already forwarded.
- res_pred_taken  in  1  prediction that fetch acted on.
- res_is_branch  out  1  combinational; res_valid and a recognised branch.
- res_taken  out  1  combinational; branch condition is true.
- res_link  out  1  combinational; BLTZAL or BGEZAL, asserted regardless of outcome.
- res_mispredict  out  1  combinational; res_is_branch and (res_taken != res_pred_taken).
- branch_cnt  out  CNT_W  count of resolved branches.
- mispred_cnt  out  CNT_W  count of mispredictions.

## Operation
- Recognised opcodes and the conditions they resolve:
  - BEQ 000100: a==b.
  - BNE 000101: a!=b.
  - BLEZ 000110: signed a<=0.
  - BGTZ 000111: signed a>0.
  - REGIMM 000001 with rt BLTZ 00000 or BLTZAL 10000: signed a<0.
  - REGIMM 000001 with rt BGEZ 00001 or BGEZAL 10001: signed a>=0.
- Any other opcode, or REGIMM with any other rt:
  - res_is_branch, res_taken, res_link and res_mispredict are all 0.
  - No PHT update and no counter change.
- All res_* outputs are 0 whenever res_valid=0. There is no latching; the outputs are purely combinational.
- PHT:
  - PHT_DEPTH entries of 2 bits; index = pc[IDX_LSB +: IDX_W].
  - The prediction is bit 1 of the entry.
- PHT update on the edge where res_is_branch=1:
  - Entry at the res_pc index increments if res_taken, decrements otherwise.
  - Counter saturates at 11 and at 00.
- Lookup:
  - On the edge where lookup_valid=1, pred_taken <= bit 1 of the entry at the lookup_pc index and pred_valid <= 1.
  - Otherwise pred_valid <= 0 and pred_taken holds its value.
- Simultaneous lookup and update to the same index is write-first: pred_taken reflects the post-update counter value.
- Statistics:
  - branch_cnt increments by 1 on each edge with res_is_branch=1.
  - mispred_cnt additionally increments when res_mispredict=1.
  - Both counters saturate at all-ones and do not wrap.

## Timing
- Resolution has zero latency: res_taken, res_link and res_mispredict are valid in the same cycle as their inputs, for decode-stage redirect and flush.
- Prediction has one-cycle latency: the lookup is sampled at edge N and pred_valid/pred_taken are valid after edge N.
- A PHT update becomes visible to lookups sampled at the same edge (write-first) and at all later edges.
- Reset is asynchronous on resetn=0 and takes effect immediately, including mid-operation:
  - Every PHT entry = 01 (weakly not-taken).
  - pred_valid=0, pred_taken=0.
  - branch_cnt=0, mispred_cnt=0.
- While resetn=0, lookups and updates are ignored. The first edge after resetn rises operates normally.
- The block has no stall input. Upstream holds res_valid low for bubbles, and a repeated res_valid=1 updates the PHT again.

## Test plan
- After reset, lookup pc=0x0040_0000 -> next cycle pred_valid=1, pred_taken=0; both counters read 0.
- BEQ a=5, b=5, pred=0 at pc=0x100 -> res_taken=1, res_mispredict=1, branch_cnt=1, mispred_cnt=1. Second resolve at pc=0x100 -> entry 11, lookup gives pred_taken=1.
- Signed conditions with a=0x8000_0000:
  - BGTZ -> taken=0.
  - BLEZ -> taken=1.
  - REGIMM rt=10000 -> taken=1, link=1.
  - REGIMM rt=10001 -> taken=0, link=1.
  - REGIMM rt=00011 -> is_branch=0, no counter change.
- Same-cycle lookup and not-taken resolve at the same index, starting from entry 10 -> pred_taken=0 (write-first). Entry saturates at 00 after further not-taken resolves.
- CNT_W=4: 20 mispredicted branches -> branch_cnt=mispred_cnt=15 with no wrap. Pulse resetn low mid-stream -> all outputs and PHT return to reset values without waiting for a clock edge.
